// File: rtl/synth_pkg.sv
// Shared constants and types for the polyphonic NCO front end.
// Optional feature macro used by phase_accumulator_bank: VOICE_STEAL_EN.
package synth_pkg;

    localparam int unsigned PHASE_W_DEFAULT = 24;
    localparam int unsigned FS_HZ           = 48000;

    // Phase increments for MIDI notes 120..131 (octave 10) at FS_HZ, 24-bit phase.
    localparam logic [23:0] BASE_INC [0:11] = '{
        24'd2926229, 24'd3100235, 24'd3284585, 24'd3479896,
        24'd3686822, 24'd3906052, 24'd4138318, 24'd4384355,
        24'd4645104, 24'd4921317, 24'd5213953, 24'd5523991
    };

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

endpackage

// File: rtl/midi_to_inc.sv
// Combinational MIDI note -> phase increment: split note into octave and
// semitone, look up the top-octave increment and shift it down per octave.
module midi_to_inc
    import synth_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEFAULT
) (
    input  logic [6:0]         note_i,
    output logic [PHASE_W-1:0] inc_o
);

    logic [3:0]  oct;
    logic [3:0]  semi;
    logic [3:0]  shift;
    logic [23:0] base;

    // Octave/semitone split and truncating shift of the base increment.
    always_comb begin
        oct   = 4'(note_i / 7'd12);
        semi  = 4'(note_i % 7'd12);
        shift = 4'd10 - oct;
        base  = BASE_INC[semi];
        inc_o = PHASE_W'(base >> shift);
    end

endmodule

// File: rtl/phase_accumulator_bank.sv
// Polyphonic NCO front end: note allocation, per-voice phase accumulators and
// a once-per-sample sweep that emits one registered slot per voice.
// Optional feature macro: VOICE_STEAL_EN (round-robin voice stealing when full).
module phase_accumulator_bank
    import synth_pkg::*;
#(
    parameter int unsigned VOICES  = 4,
    parameter int unsigned PHASE_W = PHASE_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       i_sample_tick,
    input  logic                       i_note_on,
    input  logic                       i_note_off,
    input  logic [6:0]                 i_note,
    output logic                       o_slot,
    output logic                       o_valid,
    output logic [$clog2(VOICES)-1:0]  o_voice,
    output logic [6:0]                 o_midi,
    output logic [PHASE_W-1:0]         o_phase,
    output logic                       o_last,
    output logic                       o_overrun,
    output logic                       o_drop
);

    localparam int unsigned   VI   = $clog2(VOICES);
    localparam logic [VI-1:0] LAST = VI'(VOICES - 1);

    state_t              state_q, state_d;
    logic [VI-1:0]       idx_q, idx_d;
    logic                overrun_q, overrun_d;

    logic                active_q [VOICES];
    logic                active_d [VOICES];
    logic [6:0]          note_q   [VOICES];
    logic [6:0]          note_d   [VOICES];
    logic [PHASE_W-1:0]  inc_q    [VOICES];
    logic [PHASE_W-1:0]  inc_d    [VOICES];
    logic [PHASE_W-1:0]  acc_q    [VOICES];
    logic [PHASE_W-1:0]  acc_d    [VOICES];

    logic                slot_q, valid_q, last_q, drop_q;
    logic [VI-1:0]       voice_q;
    logic [6:0]          midi_q;
    logic [PHASE_W-1:0]  phase_q;

    logic                hit, free_any, ev_on, ev_off, full;
    logic [VI-1:0]       hit_idx, free_idx, wr_idx;
    logic                wr_en, drop, emit;
    logic [PHASE_W-1:0]  new_inc, slot_phase;

    midi_to_inc #(.PHASE_W(PHASE_W)) u_inc (
        .note_i (i_note),
        .inc_o  (new_inc)
    );

    // Event decode: note-off wins over a simultaneous note-on.
    always_comb begin
        ev_off   = i_note_off;
        ev_on    = i_note_on && !i_note_off;
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (!hit && active_q[v] && (note_q[v] == i_note)) begin
                hit     = 1'b1;
                hit_idx = VI'(v);
            end
            if (!free_any && !active_q[v]) begin
                free_any = 1'b1;
                free_idx = VI'(v);
            end
        end
        full = ev_on && !hit && !free_any;
    end

`ifdef VOICE_STEAL_EN
    logic [VI-1:0] rr_q;

    // Allocation target: lowest free voice, else the round-robin victim.
    always_comb begin
        wr_en  = ev_on && !hit;
        wr_idx = free_any ? free_idx : rr_q;
        drop   = 1'b0;
    end

    // Round-robin steal pointer advances on every steal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else if (full) begin
            rr_q <= (rr_q == LAST) ? '0 : rr_q + VI'(1);
        end
    end
`else
    // Allocation target: lowest free voice; a full bank rejects the note.
    always_comb begin
        wr_en  = ev_on && !hit && free_any;
        wr_idx = free_idx;
        drop   = full;
    end
`endif

    // Sweep FSM next state, slot index and sticky overrun.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        emit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_sample_tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (i_sample_tick) overrun_d = 1'b1;
                if (clk_en) begin
                    emit = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + VI'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Voice table update: accumulate first so a same-cycle event clear wins.
    always_comb begin
        active_d   = active_q;
        note_d     = note_q;
        inc_d      = inc_q;
        acc_d      = acc_q;
        slot_phase = active_q[idx_q] ? acc_q[idx_q] + inc_q[idx_q] : '0;
        if (emit && active_q[idx_q]) acc_d[idx_q] = slot_phase;
        if (ev_off && hit) active_d[hit_idx] = 1'b0;
        if (ev_on && hit)  acc_d[hit_idx]    = '0;
        if (wr_en) begin
            active_d[wr_idx] = 1'b1;
            note_d[wr_idx]   = i_note;
            inc_d[wr_idx]    = new_inc;
            acc_d[wr_idx]    = '0;
        end
    end

    // Voice table registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                active_q[v] <= 1'b0;
                note_q[v]   <= '0;
                inc_q[v]    <= '0;
                acc_q[v]    <= '0;
            end
        end else begin
            active_q <= active_d;
            note_q   <= note_d;
            inc_q    <= inc_d;
            acc_q    <= acc_d;
        end
    end

    // Slot output registers; everything but o_slot/o_drop holds between slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= 1'b0;
            valid_q <= 1'b0;
            voice_q <= '0;
            midi_q  <= '0;
            phase_q <= '0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            slot_q <= emit;
            drop_q <= drop;
            if (emit) begin
                valid_q <= active_q[idx_q];
                voice_q <= idx_q;
                midi_q  <= active_q[idx_q] ? note_q[idx_q] : 7'd0;
                phase_q <= slot_phase;
                last_q  <= (idx_q == LAST);
            end
        end
    end

    assign o_slot    = slot_q;
    assign o_valid   = valid_q;
    assign o_voice   = voice_q;
    assign o_midi    = midi_q;
    assign o_phase   = phase_q;
    assign o_last    = last_q;
    assign o_overrun = overrun_q;
    assign o_drop    = drop_q;

endmodule
